// File: rtl/mipi_pkg.sv
// Shared types and constants for the MIPI TX scheduler.
// Holds the FSM state encoding, the confirmation payload word and default timing.
package mipi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAKE = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // ASCII "yako", zero-extended into the payload bus on confirmation messages.
    localparam logic [31:0] CONFIRM_WORD = 32'h79_61_6b_6f;

    localparam int DEF_DLEN           = 512;
    localparam int DEF_WAKE_CYCLES    = 1024;
    localparam int DEF_FRAMES_PER_MSG = 2;
    localparam int DEF_GAP_CYCLES     = 256;
    localparam int DEF_TIMEOUT_CYCLES = 16777216;
    localparam int DEF_CNT_W          = 24;

endpackage

// File: rtl/mipi_req_arb.sv
// Request latches and round-robin arbiter for the ack and result requesters.
// Win decision is combinational in IDLE; grant/drop pulses are registered (+1 cycle). Requests never stall.
module mipi_req_arb #(
    parameter int PW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_ack_req,
    input  logic          i_res_req,
    input  logic [PW-1:0] i_res_data,
    input  logic          i_idle,
    output logic          o_ack_win,
    output logic          o_res_win,
    output logic [PW-1:0] o_res_dat,
    output logic          o_ack_grant,
    output logic          o_res_grant,
    output logic          o_res_drop
);

    logic          r_ack_pend;
    logic          r_res_pend;
    logic          r_last_ack;
    logic [PW-1:0] r_res_buf;
    logic          r_ack_grant;
    logic          r_res_grant;
    logic          r_res_drop;

    logic w_ack_eff;
    logic w_res_eff;
    logic w_both;

    // A request arriving on the decision cycle counts as pending, giving request->grant in one cycle.
    assign w_ack_eff = r_ack_pend | i_ack_req;
    assign w_res_eff = r_res_pend | i_res_req;
    assign w_both    = w_ack_eff & w_res_eff;

    assign o_ack_win = i_idle & w_ack_eff & (~w_res_eff | ~r_last_ack);
    assign o_res_win = i_idle & w_res_eff & (~w_ack_eff | r_last_ack);
    assign o_res_dat = i_res_req ? i_res_data : r_res_buf;

    assign o_ack_grant = r_ack_grant;
    assign o_res_grant = r_res_grant;
    assign o_res_drop  = r_res_drop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ack_pend  <= 1'b0;
            r_res_pend  <= 1'b0;
            r_last_ack  <= 1'b0;
            r_res_buf   <= '0;
            r_ack_grant <= 1'b0;
            r_res_grant <= 1'b0;
            r_res_drop  <= 1'b0;
        end else begin
            r_ack_pend  <= w_ack_eff & ~o_ack_win;
            r_res_pend  <= w_res_eff & ~o_res_win;
            if (i_res_req) begin
                r_res_buf <= i_res_data;
            end
            r_res_drop  <= i_res_req & r_res_pend;
            r_ack_grant <= o_ack_win;
            r_res_grant <= o_res_win;
            // Priority only flips on contested grants, so a lone request never steals the other's turn.
            if (i_idle && w_both) begin
                r_last_ack <= o_ack_win;
            end
        end
    end

endmodule

// File: rtl/mipi_tx_scheduler.sv
// Shares the MIPI TX link between ack and result messages: WAKE -> SEND frames -> GAP.
// Grant one cycle after request in IDLE; requests arriving while busy are held pending, never refused.
module mipi_tx_scheduler
    import mipi_pkg::*;
#(
    parameter int DLEN           = DEF_DLEN,
    parameter int WAKE_CYCLES    = DEF_WAKE_CYCLES,
    parameter int FRAMES_PER_MSG = DEF_FRAMES_PER_MSG,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic              i_tx_pixel_clk,
    input  logic              i_rst_n,
    input  logic              i_ack_req,
    input  logic              i_res_req,
    input  logic [DLEN*8-1:0] i_res_data,
    input  logic              i_frame_done,
    output logic              o_ack_grant,
    output logic              o_res_grant,
    output logic              o_tx_en,
    output logic              o_busy,
    output logic              o_sel_confirm,
    output logic [DLEN*8-1:0] o_payload,
    output logic              o_res_drop,
    output logic              o_timeout_err
);

    localparam int PW = DLEN * 8;
    localparam int FW = $clog2(FRAMES_PER_MSG + 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [FW-1:0]   r_frm;
    logic [FW-1:0]   w_frm_nxt;
    logic            w_timeout;
    logic            r_timeout_err;
    logic            r_sel_confirm;
    logic [PW-1:0]   r_payload;
    logic [PW-1:0]   w_confirm;
    logic [PW-1:0]   w_res_dat;
    logic            w_idle;
    logic            w_ack_win;
    logic            w_res_win;

    assign w_idle = (r_state == ST_IDLE);

    mipi_req_arb #(
        .PW (PW)
    ) u_arb (
        .i_clk       (i_tx_pixel_clk),
        .i_rst_n     (i_rst_n),
        .i_ack_req   (i_ack_req),
        .i_res_req   (i_res_req),
        .i_res_data  (i_res_data),
        .i_idle      (w_idle),
        .o_ack_win   (w_ack_win),
        .o_res_win   (w_res_win),
        .o_res_dat   (w_res_dat),
        .o_ack_grant (o_ack_grant),
        .o_res_grant (o_res_grant),
        .o_res_drop  (o_res_drop)
    );

    always_comb begin
        w_confirm       = '0;
        w_confirm[31:0] = CONFIRM_WORD;
    end

    always_ff @(posedge i_tx_pixel_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_frm   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_frm   <= w_frm_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_frm_nxt   = r_frm;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ack_win || w_res_win) begin
                    w_state_nxt = ST_WAKE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_WAKE: begin
                if (r_cnt == CNT_W'(WAKE_CYCLES - 1)) begin
                    w_state_nxt = ST_SEND;
                    w_cnt_nxt   = '0;
                    w_frm_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_SEND: begin
                if (i_frame_done) begin
                    w_cnt_nxt = '0;
                    if (r_frm == FW'(FRAMES_PER_MSG - 1)) begin
                        w_state_nxt = ST_GAP;
                        w_frm_nxt   = '0;
                    end else begin
                        w_frm_nxt = r_frm + FW'(1);
                    end
                end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Abandon the message; it is not retried.
                    w_state_nxt = ST_GAP;
                    w_cnt_nxt   = '0;
                    w_frm_nxt   = '0;
                    w_timeout   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_frm_nxt   = '0;
            end
        endcase
    end

    // Payload and selector stay with the last message until the next grant.
    always_ff @(posedge i_tx_pixel_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_payload     <= '0;
            r_sel_confirm <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if (w_ack_win) begin
                r_payload     <= w_confirm;
                r_sel_confirm <= 1'b1;
            end else if (w_res_win) begin
                r_payload     <= w_res_dat;
                r_sel_confirm <= 1'b0;
            end
        end
    end

    assign o_tx_en       = (r_state == ST_WAKE) || (r_state == ST_SEND);
    assign o_busy        = (r_state != ST_IDLE);
    assign o_sel_confirm = r_sel_confirm;
    assign o_payload     = r_payload;
    assign o_timeout_err = r_timeout_err;

endmodule
